// File: rtl/cdc_channel_arbiter.sv
// cdc_channel_arbiter: round-robin arbiter feeding one four-phase mux-handshake CDC channel.
// Define CDC_ARB_TIMEOUT_EN to build the sticky ack-timeout monitor.
module cdc_channel_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_arst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic                          o_sync_wr,
    output logic [DATA_WIDTH-1:0]         o_sync_data,
    input  logic                          i_sync_rdy,
    input  logic                          i_sync_ack,
    output logic                          o_busy,
    output logic                          o_timeout,
    output logic [ID_W-1:0]               o_timeout_id
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cdc_channel_arbiter: unsupported parameter set");
    end

    logic [1:0] state;
    logic [ID_W-1:0] ptr, id, off, win, ptr_nxt;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0] sum;
    logic found, go;

    // Rotate the request vector so the pointer sits at bit 0, then take the lowest set bit.
    assign dbl = {i_req, i_req} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        found = 1'b0;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) begin
                found = 1'b1;
                off = ID_W'(i);
            end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign win = (sum >= (ID_W + 1)'(NUM_REQ)) ? ID_W'(sum - (ID_W + 1)'(NUM_REQ)) : sum[ID_W-1:0];
    assign ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign go = found && i_sync_rdy && !i_sync_ack;
    assign o_busy = state != IDLE;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= IDLE;
            ptr <= '0;
            id <= '0;
            o_sync_data <= '0;
            o_sync_wr <= 1'b0;
            o_grant <= '0;
            o_done <= '0;
        end else begin
            o_sync_wr <= 1'b0;
            o_grant <= '0;
            o_done <= (state == WAIT_ACK && i_sync_ack) ? NUM_REQ'(1) << id : '0;
            case (state)
                IDLE:
                    if (go) begin
                        state <= WRITE;
                        id <= win;
                        ptr <= ptr_nxt;
                        o_sync_data <= i_data[win*DATA_WIDTH +: DATA_WIDTH];
                        o_sync_wr <= 1'b1;
                        o_grant <= NUM_REQ'(1) << win;
                    end
                WRITE: state <= WAIT_ACK;
                WAIT_ACK: if (i_sync_ack) state <= WAIT_REL;
                default: if (!i_sync_ack && i_sync_rdy) state <= IDLE;
            endcase
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Monitor only: the handshake keeps waiting after the flag is raised.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt <= '0;
            o_timeout <= 1'b0;
            o_timeout_id <= '0;
        end else begin
            if (state == WRITE) cnt <= '0;
            else if (state == WAIT_ACK && cnt != CNT_W'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
            if (state == WAIT_ACK && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                o_timeout <= 1'b1;
                o_timeout_id <= id;
            end
        end
    end
`else
    assign o_timeout = 1'b0;
    assign o_timeout_id = '0;
`endif
endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// tb_cdc_channel_arbiter: directed checks of arbitration order, handshake sequencing, reset and timeout flag.
module tb_cdc_channel_arbiter;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic [3:0] req = '0;
    logic [31:0] data = '0;
    logic [3:0] grant, done;
    logic sync_wr, sync_rdy = 1'b1, sync_ack = 1'b0;
    logic [7:0] sync_data;
    logic busy, timeout;
    logic [1:0] timeout_id;
    int checks = 0;
    int errors = 0;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    cdc_channel_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_req(req), .i_data(data),
        .o_grant(grant), .o_done(done), .o_sync_wr(sync_wr), .o_sync_data(sync_data),
        .i_sync_rdy(sync_rdy), .i_sync_ack(sync_ack), .o_busy(busy),
        .o_timeout(timeout), .o_timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        req = '0;
        sync_rdy = 1'b1;
        sync_ack = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
        tick();
    endtask

    // Drives the channel side from the WRITE cycle through release back to IDLE.
    task automatic finish_xfer(input string tag, input logic [3:0] g);
        sync_rdy = 1'b0;
        tick();
        chk({tag, "_wr_low"}, sync_wr, 0);
        chk({tag, "_grant_low"}, grant, 0);
        chk({tag, "_busy"}, busy, 1);
        tick();
        sync_ack = 1'b1;
        tick();
        chk({tag, "_done"}, done, g);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        sync_ack = 1'b0;
        sync_rdy = 1'b1;
        tick();
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic xfer(input string tag, input logic [3:0] g, input logic [7:0] d, input bit keep);
        tick();
        chk({tag, "_wr"}, sync_wr, 1);
        chk({tag, "_grant"}, grant, g);
        chk({tag, "_data"}, sync_data, d);
        if (!keep) req = req & ~g;
        finish_xfer(tag, g);
    endtask

    initial begin
        do_reset();
        chk("rst_wr", sync_wr, 0);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_data", sync_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_to", timeout, 0);
        chk("rst_to_id", timeout_id, 0);

        data = 32'h0000_00A5;
        req = 4'b0001;
        xfer("single", 4'b0001, 8'hA5, 1'b0);

        do_reset();
        data = 32'h4433_2211;
        req = 4'b1111;
        xfer("all0", 4'b0001, 8'h11, 1'b0);
        xfer("all1", 4'b0010, 8'h22, 1'b0);
        xfer("all2", 4'b0100, 8'h33, 1'b0);
        xfer("all3", 4'b1000, 8'h44, 1'b0);

        do_reset();
        data = 32'h00C2_00C0;
        req = 4'b0101;
        for (int i = 0; i < 6; i++)
            xfer($sformatf("fair%0d", i), (i % 2 == 0) ? 4'b0001 : 4'b0100,
                 (i % 2 == 0) ? 8'hC0 : 8'hC2, 1'b1);
        req = '0;
        tick();

        data = 32'h0000_7700;
        sync_ack = 1'b1;
        req = 4'b0010;
        repeat (3) tick();
        chk("busy_ack_wr", sync_wr, 0);
        chk("busy_ack_idle", busy, 0);
        sync_ack = 1'b0;
        sync_rdy = 1'b0;
        tick();
        chk("busy_rdy_wr", sync_wr, 0);
        sync_rdy = 1'b1;
        tick();
        chk("busy_go_wr", sync_wr, 1);
        chk("busy_go_grant", grant, 4'b0010);
        chk("busy_go_data", sync_data, 8'h77);
        req = '0;
        finish_xfer("busy", 4'b0010);

        data = 32'h3C00_0000;
        req = 4'b1000;
        tick();
        chk("mrst_wr", sync_wr, 1);
        req = '0;
        sync_rdy = 1'b0;
        tick();
        tick();
        arst_n = 1'b0;
        #1;
        chk("mrst_wr0", sync_wr, 0);
        chk("mrst_data0", sync_data, 0);
        chk("mrst_busy0", busy, 0);
        chk("mrst_grant0", grant, 0);
        sync_ack = 1'b0;
        sync_rdy = 1'b1;
        tick();
        chk("mrst_done0", done, 0);
        tick();
        arst_n = 1'b1;
        tick();
        chk("mrst_done1", done, 0);
        data = 32'h005A_0000;
        req = 4'b0100;
        xfer("mrst_after", 4'b0100, 8'h5A, 1'b0);

        data = 32'h00E1_0000;
        req = 4'b0100;
        tick();
        chk("to_wr", sync_wr, 1);
        req = '0;
        sync_rdy = 1'b0;
        tick();
        repeat (15) tick();
        chk("to_pre", timeout, 0);
        tick();
        chk("to_flag", timeout, TO_EN);
        chk("to_id", timeout_id, TO_EN ? 2 : 0);
        chk("to_busy", busy, 1);
        sync_ack = 1'b1;
        tick();
        chk("to_done", done, 4'b0100);
        tick();
        sync_ack = 1'b0;
        sync_rdy = 1'b1;
        tick();
        chk("to_idle", busy, 0);
        chk("to_sticky", timeout, TO_EN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
